conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_seq_pkg.sv | 30 +++
 rtl/conv_seq_cnt.sv | 43 ++++
 rtl/conv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_conv_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution pixel sequencer: state encoding,
// counter width and default configuration constants.
package conv_seq_pkg;

    localparam int unsigned CNT_W = 16;

    localparam int unsigned DEF_NUM_KERNEL = 9;
    localparam int unsigned DEF_LOAD_TOTAL = 28;
    localparam int unsigned DEF_NUM_IMAGE  = 90;
    localparam int unsigned DEF_RST_CYCLES = 4;
    localparam int unsigned DEF_KERN_BASE  = 0;
    localparam int unsigned DEF_IMG_BASE   = 16;
    localparam int unsigned DEF_ADDR_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RESET1      = 3'd1,
        ST_LOAD_KERNEL = 3'd2,
        ST_PAD         = 3'd3,
        ST_RESET2      = 3'd4,
        ST_CONVOLVE    = 3'd5,
        ST_DONE        = 3'd6
    } state_e;

    // Sequencer is busy in every state except the two resting states.
    function automatic logic state_is_busy(input state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/conv_seq_cnt.sv
// Shared pixel-slot counter: clear / load-one / increment, plus an equality
// compare against a terminal value chosen by the sequencer each cycle.
module conv_seq_cnt
    import conv_seq_pkg::*;
(
    input  logic             clk,
    input  logic             srst_n,
    input  logic             clr_i,
    input  logic             load_one_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over load, load wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_one_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/conv_sequencer.sv
// Convolution engine pixel sequencer: resets the engine, streams kernel
// coefficients and zero padding, resets again, then streams the image.
// Optional feature: define CONV_SEQ_STALL_CNT_EN to add Stall_Cnt_s1, a
// saturating count of CONVOLVE cycles in which the engine was not ready.
module conv_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned NUM_KERNEL = DEF_NUM_KERNEL,
    parameter int unsigned LOAD_TOTAL = DEF_LOAD_TOTAL,
    parameter int unsigned NUM_IMAGE  = DEF_NUM_IMAGE,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned KERN_BASE  = DEF_KERN_BASE,
    parameter int unsigned IMG_BASE   = DEF_IMG_BASE,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              Phi2,
    input  logic              Reset_b_s1,
    input  logic              Start_s1,
    input  logic              Input_Ready_s1,
    output logic [ADDR_W-1:0] Rd_Addr_s1,
    input  logic [7:0]        Rd_Data_s1,
    output logic [7:0]        Pixel_s1,
    output logic              Eng_Reset_s1,
    output logic              Busy_s1,
    output logic              Done_s1
`ifdef CONV_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       Stall_Cnt_s1
`endif
);

    localparam logic [CNT_W-1:0] KERN_LAST = CNT_W'(NUM_KERNEL - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TOTAL - 1);
    localparam logic [CNT_W-1:0] IMG_TERM  = CNT_W'(NUM_IMAGE);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam bit               NO_PAD    = (NUM_KERNEL == LOAD_TOTAL);

    state_e           state_q, state_d;
    logic [7:0]       pixel_q, pixel_d;
    logic             eng_rst_q, eng_rst_d;
    // Engine-reset timer kept apart from Cnt so the read address stays at the
    // base during reset and the first pixel is ready on the terminal edge.
    logic [CNT_W-1:0] rst_tmr_q, rst_tmr_d;

    logic             cnt_clr;
    logic             cnt_load_one;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] cnt;
    logic             cnt_at_term;

`ifdef CONV_SEQ_STALL_CNT_EN
    logic [15:0]      stall_q, stall_d;
`endif

    conv_seq_cnt u_cnt (
        .clk        (Phi2),
        .srst_n     (Reset_b_s1),
        .clr_i      (cnt_clr),
        .load_one_i (cnt_load_one),
        .inc_i      (cnt_inc),
        .term_i     (cnt_term),
        .cnt_o      (cnt),
        .at_term_o  (cnt_at_term)
    );

    // Next-state, pixel, engine-reset and counter-control decode.
    always_comb begin
        state_d      = state_q;
        pixel_d      = pixel_q;
        eng_rst_d    = eng_rst_q;
        rst_tmr_d    = rst_tmr_q;
        cnt_clr      = 1'b0;
        cnt_load_one = 1'b0;
        cnt_inc      = 1'b0;
        cnt_term     = '0;
`ifdef CONV_SEQ_STALL_CNT_EN
        stall_d      = stall_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start_s1) begin
                    state_d   = ST_RESET1;
                    cnt_clr   = 1'b1;
                    eng_rst_d = 1'b1;
                    rst_tmr_d = '0;
`ifdef CONV_SEQ_STALL_CNT_EN
                    stall_d   = '0;
`endif
                end
            end
            ST_RESET1, ST_RESET2: begin
                if (rst_tmr_q == RST_LAST) begin
                    // Address sits at the base here, so Rd_Data is pixel 0.
                    pixel_d      = Rd_Data_s1;
                    eng_rst_d    = 1'b0;
                    cnt_load_one = 1'b1;
                    state_d      = (state_q == ST_RESET1) ? ST_LOAD_KERNEL : ST_CONVOLVE;
                end else begin
                    rst_tmr_d = rst_tmr_q + CNT_W'(1);
                end
            end
            ST_LOAD_KERNEL: begin
                cnt_term = KERN_LAST;
                if (Input_Ready_s1) begin
                    pixel_d = Rd_Data_s1;
                    cnt_inc = 1'b1;
                    if (cnt_at_term) begin
                        if (NO_PAD) begin
                            state_d   = ST_RESET2;
                            cnt_clr   = 1'b1;
                            eng_rst_d = 1'b1;
                            rst_tmr_d = '0;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                cnt_term = LOAD_LAST;
                if (Input_Ready_s1) begin
                    pixel_d = 8'd0;
                    cnt_inc = 1'b1;
                    if (cnt_at_term) begin
                        state_d   = ST_RESET2;
                        cnt_clr   = 1'b1;
                        eng_rst_d = 1'b1;
                        rst_tmr_d = '0;
                    end
                end
            end
            ST_CONVOLVE: begin
                cnt_term = IMG_TERM;
                if (cnt_at_term) begin
                    // Last image pixel already delivered; finish regardless of ready.
                    state_d = ST_DONE;
                end else if (Input_Ready_s1) begin
                    pixel_d = Rd_Data_s1;
                    cnt_inc = 1'b1;
                end
`ifdef CONV_SEQ_STALL_CNT_EN
                if (!Input_Ready_s1 && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the engine into reset.
    always_ff @(posedge Phi2) begin
        if (!Reset_b_s1) begin
            state_q   <= ST_IDLE;
            pixel_q   <= 8'd0;
            eng_rst_q <= 1'b1;
            rst_tmr_q <= '0;
`ifdef CONV_SEQ_STALL_CNT_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pixel_q   <= pixel_d;
            eng_rst_q <= eng_rst_d;
            rst_tmr_q <= rst_tmr_d;
`ifdef CONV_SEQ_STALL_CNT_EN
            stall_q   <= stall_d;
`endif
        end
    end

    // Read address follows the count within the kernel or image window; wraps.
    always_comb begin
        case (state_q)
            ST_RESET1, ST_LOAD_KERNEL: Rd_Addr_s1 = ADDR_W'(KERN_BASE) + ADDR_W'(cnt);
            ST_RESET2, ST_CONVOLVE:    Rd_Addr_s1 = ADDR_W'(IMG_BASE) + ADDR_W'(cnt);
            default:                   Rd_Addr_s1 = '0;
        endcase
    end

    assign Pixel_s1     = pixel_q;
    assign Eng_Reset_s1 = eng_rst_q;
    assign Busy_s1      = state_is_busy(state_q);
    assign Done_s1      = (state_q == ST_DONE);
`ifdef CONV_SEQ_STALL_CNT_EN
    assign Stall_Cnt_s1 = stall_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: default instance plus a no-pad,
// single-image-pixel instance sharing the clock and reset.
module tb_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start, ir;
    logic [7:0] rd_addr, rd_data, pixel;
    logic       eng_rst, busy, done;
    logic       b_start, b_ir;
    logic [7:0] b_rd_addr, b_rd_data, b_pixel;
    logic       b_eng_rst, b_busy, b_done;
`ifdef CONV_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt, b_stall_cnt;
`endif

    logic [7:0] mem [0:255];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rd_data   = mem[rd_addr];
    assign b_rd_data = mem[b_rd_addr];

    conv_sequencer dut (
        .Phi2(clk), .Reset_b_s1(rst_b), .Start_s1(start), .Input_Ready_s1(ir),
        .Rd_Addr_s1(rd_addr), .Rd_Data_s1(rd_data), .Pixel_s1(pixel),
        .Eng_Reset_s1(eng_rst), .Busy_s1(busy), .Done_s1(done)
`ifdef CONV_SEQ_STALL_CNT_EN
        , .Stall_Cnt_s1(stall_cnt)
`endif
    );

    conv_sequencer #(.NUM_KERNEL(9), .LOAD_TOTAL(9), .NUM_IMAGE(1)) dut_b (
        .Phi2(clk), .Reset_b_s1(rst_b), .Start_s1(b_start), .Input_Ready_s1(b_ir),
        .Rd_Addr_s1(b_rd_addr), .Rd_Data_s1(b_rd_data), .Pixel_s1(b_pixel),
        .Eng_Reset_s1(b_eng_rst), .Busy_s1(b_busy), .Done_s1(b_done)
`ifdef CONV_SEQ_STALL_CNT_EN
        , .Stall_Cnt_s1(b_stall_cnt)
`endif
    );

    // Expected memory content at an address (never zero for used addresses).
    function automatic logic [7:0] px(input int a);
        return 8'((a * 3 + 'h51) & 'hFF);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full run with ready held high; optional Start pulse inside LOAD_KERNEL.
    task automatic full_run(input string name, input bit pulse_in_load);
        ir = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({name, " r1_eng"}, 16'(eng_rst), 16'd1);
        chk({name, " r1_busy"}, 16'(busy), 16'd1);
        chk({name, " r1_done"}, 16'(done), 16'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk({name, " r1_eng"}, 16'(eng_rst), 16'd1);
        end
        step();
        chk({name, " k0_pix"}, 16'(pixel), 16'(px(0)));
        chk({name, " k0_eng"}, 16'(eng_rst), 16'd0);
        for (int k = 1; k <= 8; k++) begin
            if (pulse_in_load && k == 3) start = 1'b1;
            step();
            start = 1'b0;
            chk({name, " k_pix"}, 16'(pixel), 16'(px(k)));
            chk({name, " k_busy"}, 16'(busy), 16'd1);
        end
        for (int z = 0; z < 19; z++) begin
            step();
            chk({name, " pad_pix"}, 16'(pixel), 16'd0);
        end
        chk({name, " r2_eng"}, 16'(eng_rst), 16'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk({name, " r2_eng"}, 16'(eng_rst), 16'd1);
            chk({name, " r2_addr"}, 16'(rd_addr), 16'd16);
        end
        step();
        chk({name, " i0_pix"}, 16'(pixel), 16'(px(16)));
        chk({name, " i0_eng"}, 16'(eng_rst), 16'd0);
        for (int k = 17; k <= 105; k++) begin
            step();
            chk({name, " img_pix"}, 16'(pixel), 16'(px(k)));
        end
        chk({name, " pre_done"}, 16'(done), 16'd0);
        step();
        chk({name, " done"}, 16'(done), 16'd1);
        chk({name, " done_busy"}, 16'(busy), 16'd0);
        $display("[TB] run %s complete, %0d checks so far", name, tests);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = px(a);
        rst_b = 1'b0; start = 1'b0; ir = 1'b1; b_start = 1'b0; b_ir = 1'b1;
        step();
        step();
        chk("rst_pix", 16'(pixel), 16'd0);
        chk("rst_eng", 16'(eng_rst), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_addr", 16'(rd_addr), 16'd0);
        chk("rst_b_pix", 16'(b_pixel), 16'd0);
        rst_b = 1'b1;
        step();
        chk("idle_busy", 16'(busy), 16'd0);
        $display("[TB] reset sequence complete");

        // Run 1 with a Start pulse in LOAD_KERNEL, then Start from DONE.
        full_run("run1", 1'b1);
        full_run("run2_from_done", 1'b0);

        // Run 3: alternate ready in CONVOLVE, then reset at Cnt=40.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 35; i++) step();
        chk("alt_i0_pix", 16'(pixel), 16'(px(16)));
        chk("alt_i0_addr", 16'(rd_addr), 16'd17);
        for (int k = 1; k <= 39; k++) begin
            ir = 1'b1;
            step();
            chk("alt_pix_adv", 16'(pixel), 16'(px(16 + k)));
            chk("alt_addr_adv", 16'(rd_addr), 16'(17 + k));
            ir = 1'b0;
            step();
            chk("alt_pix_hold", 16'(pixel), 16'(px(16 + k)));
            chk("alt_addr_hold", 16'(rd_addr), 16'(17 + k));
        end
        ir = 1'b1;
        rst_b = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        rst_b = 1'b1;
        chk("mid_rst_pix", 16'(pixel), 16'd0);
        chk("mid_rst_eng", 16'(eng_rst), 16'd1);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_done", 16'(done), 16'd0);
        $display("[TB] run alternating-ready with mid-run reset complete");
        full_run("run4_after_reset", 1'b0);

`ifdef CONV_SEQ_STALL_CNT_EN
        // Stall counting: 5 idle cycles in LOAD_KERNEL, 7 in CONVOLVE.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("stall_clr", stall_cnt, 16'd0);
        for (int i = 0; i < 4; i++) step();
        ir = 1'b0;
        for (int i = 0; i < 5; i++) step();
        ir = 1'b1;
        for (int i = 0; i < 31; i++) step();
        chk("stall_i0_pix", 16'(pixel), 16'(px(16)));
        ir = 1'b0;
        for (int i = 0; i < 7; i++) step();
        ir = 1'b1;
        for (int i = 0; i < 90; i++) step();
        chk("stall_done", 16'(done), 16'd1);
        chk("stall_cnt", stall_cnt, 16'd7);
        ir = 1'b0;
        step();
        step();
        chk("stall_hold", stall_cnt, 16'd7);
        ir = 1'b1;
        $display("[TB] run stall-count complete");
`endif

        // No-pad, single-image-pixel instance.
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("b_r1_eng", 16'(b_eng_rst), 16'd1);
        for (int i = 1; i < 4; i++) step();
        chk("b_r1_eng_last", 16'(b_eng_rst), 16'd1);
        step();
        chk("b_k0_pix", 16'(b_pixel), 16'(px(0)));
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("b_k_pix", 16'(b_pixel), 16'(px(k)));
        end
        chk("b_r2_eng", 16'(b_eng_rst), 16'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("b_r2_pix_nonzero", 16'(b_pixel), 16'(px(8)));
        end
        step();
        chk("b_i0_pix", 16'(b_pixel), 16'(px(16)));
        chk("b_i0_done", 16'(b_done), 16'd0);
        chk("b_i0_busy", 16'(b_busy), 16'd1);
        step();
        chk("b_done", 16'(b_done), 16'd1);
        chk("b_done_pix", 16'(b_pixel), 16'(px(16)));
        $display("[TB] run no-pad instance complete");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
